// File: rtl/seg7_timer_display.sv
// Four-digit BCD up/down timer with run/pause/clear control and a multiplexed
// seven-segment display driver; all tick and button inputs are synchronised into clk.
module seg7_timer_display #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_2Hz,
    input  logic        clk_1kHz,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        up_down,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [15:0] bcd,
    output logic        running,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    // Bit order of the synchroniser vectors: {clear, start_stop, clk_1kHz, clk_2Hz}
    logic [3:0]  sync1_q, sync2_q, sync3_q;
    logic        ud1_q, ud2_q;
    logic [3:0]  pulse_s;
    logic        tick2_s, tick1k_s, start_p_s, clear_p_s;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        running_q, running_d;
    logic        done_q, done_d;

    logic [1:0]  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        dp_q, dp_d;
    logic [3:0]  digit_s;
    logic        upper_zero_s;
    logic [6:0]  seg_raw_s;
    logic [3:0]  an_raw_s;
    logic        dp_raw_s;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (c) begin
                if (v[4*k +: 4] >= 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                    c           = 1'b1;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (b) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                    b           = 1'b1;
                end else if (v[4*k +: 4] > 4'd9) begin
                    r[4*k +: 4] = 4'd9;
                    b           = 1'b0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    // Segment pattern {g,f,e,d,c,b,a}, 1 = lit
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // Input synchronisers and edge-detect history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            sync3_q <= 4'b0000;
            ud1_q   <= 1'b0;
            ud2_q   <= 1'b0;
        end else begin
            sync1_q <= {clear, start_stop, clk_1kHz, clk_2Hz};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            ud1_q   <= up_down;
            ud2_q   <= ud1_q;
        end
    end

    assign pulse_s   = sync2_q & ~sync3_q;
    assign tick2_s   = pulse_s[0];
    assign tick1k_s  = pulse_s[1];
    assign start_p_s = pulse_s[2];
    assign clear_p_s = pulse_s[3];

    // Control FSM and counter state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'h0000;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // Next state and count: clear beats start, start beats the count tick
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (clear_p_s) begin
            state_d = ST_IDLE;
            cnt_d   = 16'h0000;
        end else if (start_p_s) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end else if (tick2_s && (state_q == ST_RUN)) begin
            if (ud2_q) begin
                cnt_d = bcd_inc(cnt_q);
            end else if ((cnt_q == 16'h0000) || (cnt_q == 16'h0001)) begin
                cnt_d   = 16'h0000;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                cnt_d = bcd_dec(cnt_q);
            end
        end else begin
            state_d = state_q;
        end
        running_d = (state_d == ST_RUN);
    end

    // Display source selection, blanking and polarity
    always_comb begin
        digit_s      = 4'd0;
        upper_zero_s = 1'b0;
        case (idx_q)
            2'd0: begin
                digit_s      = cnt_q[3:0];
                upper_zero_s = 1'b0;
            end
            2'd1: begin
                digit_s      = cnt_q[7:4];
                upper_zero_s = (cnt_q[15:4] == 12'h000);
            end
            2'd2: begin
                digit_s      = cnt_q[11:8];
                upper_zero_s = (cnt_q[15:8] == 8'h00);
            end
            2'd3: begin
                digit_s      = cnt_q[15:12];
                upper_zero_s = (cnt_q[15:12] == 4'h0);
            end
            default: begin
                digit_s      = 4'd0;
                upper_zero_s = 1'b0;
            end
        endcase
        if (BLANK_LEADING && upper_zero_s) begin
            seg_raw_s = 7'h00;
        end else begin
            seg_raw_s = seg_decode(digit_s);
        end
        an_raw_s = 4'b0001 << idx_q;
        dp_raw_s = (idx_q == 2'd0) && running_q;
        seg_d    = SEG_ACTIVE_LOW ? ~seg_raw_s : seg_raw_s;
        an_d     = AN_ACTIVE_LOW ? ~an_raw_s : an_raw_s;
        dp_d     = SEG_ACTIVE_LOW ? ~dp_raw_s : dp_raw_s;
        idx_d    = idx_q + 2'd1;
    end

    // Display registers advance only on the scan tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= 2'd0;
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
            dp_q  <= DP_OFF;
        end else if (tick1k_s) begin
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end else begin
            idx_q <= idx_q;
            seg_q <= seg_q;
            an_q  <= an_q;
            dp_q  <= dp_q;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign dp      = dp_q;
    assign bcd     = cnt_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seg7_timer_display.sv
// Directed bench for seg7_timer_display: a decimal-count model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_seg7_timer_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_2Hz = 1'b0;
    logic        clk_1kHz = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        up_down = 1'b1;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [15:0] bcd;
    logic        running;
    logic        done;

    int checks = 0;
    int errors = 0;

    seg7_timer_display dut (
        .clk(clk), .rst(rst), .clk_2Hz(clk_2Hz), .clk_1kHz(clk_1kHz),
        .start_stop(start_stop), .clear(clear), .up_down(up_down),
        .seg(seg), .dp(dp), .an(an), .bcd(bcd), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: decimal count, mode 0 idle / 1 run / 2 pause, histories of sampled inputs
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAUSE = 2;
    int         p10 [4] = '{1, 10, 100, 1000};
    logic [6:0] lit [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int         m_cnt = 0;
    int         m_mode = M_IDLE;
    bit         m_done = 1'b0;
    int         m_idx = 0;
    logic [6:0] m_seg = 7'h7F;
    logic [3:0] m_an = 4'hF;
    logic       m_dp = 1'b1;
    logic [2:0] hist [4] = '{3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] ud_hist = 3'b000;
    bit         cmp_en = 1'b1;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Edge n of an input counts as a pulse two clocks after it is first sampled high
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt   <= 0;
            m_mode  <= M_IDLE;
            m_done  <= 1'b0;
            m_idx   <= 0;
            m_seg   <= 7'h7F;
            m_an    <= 4'hF;
            m_dp    <= 1'b1;
            hist    <= '{3'b000, 3'b000, 3'b000, 3'b000};
            ud_hist <= 3'b000;
        end else begin
            bit tk, t1k, sp, cp, up, dn, blank;
            int c, md, dg;
            logic [6:0] pat;
            tk  = hist[0][1] & ~hist[0][2];
            t1k = hist[1][1] & ~hist[1][2];
            sp  = hist[2][1] & ~hist[2][2];
            cp  = hist[3][1] & ~hist[3][2];
            up  = ud_hist[1];
            c   = m_cnt;
            md  = m_mode;
            dn  = 1'b0;
            if (cp) begin
                md = M_IDLE;
                c  = 0;
            end else if (sp) begin
                md = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
            end else if (tk && m_mode == M_RUN) begin
                if (up) begin
                    c = (m_cnt + 1) % 10000;
                end else if (m_cnt <= 1) begin
                    c  = 0;
                    dn = 1'b1;
                    md = M_IDLE;
                end else begin
                    c = m_cnt - 1;
                end
            end
            if (t1k) begin
                dg    = (m_cnt / p10[m_idx]) % 10;
                blank = (m_idx > 0) && ((m_cnt / p10[m_idx]) == 0);
                pat   = blank ? 7'h00 : lit[dg];
                m_seg <= ~pat;
                m_an  <= ~(4'b0001 << m_idx);
                m_dp  <= !((m_idx == 0) && (m_mode == M_RUN));
                m_idx <= (m_idx + 1) % 4;
            end
            m_cnt  <= c;
            m_mode <= md;
            m_done <= dn;
            hist[0] <= {hist[0][1:0], clk_2Hz};
            hist[1] <= {hist[1][1:0], clk_1kHz};
            hist[2] <= {hist[2][1:0], start_stop};
            hist[3] <= {hist[3][1:0], clear};
            ud_hist <= {ud_hist[1:0], up_down};
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_bcd", bcd, to_bcd(m_cnt));
            chk("m_running", {15'd0, running}, {15'd0, (m_mode == M_RUN)});
            chk("m_done", {15'd0, done}, {15'd0, m_done});
            chk("m_seg", {9'd0, seg}, {9'd0, m_seg});
            chk("m_an", {12'd0, an}, {12'd0, m_an});
            chk("m_dp", {15'd0, dp}, {15'd0, m_dp});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick2();
        clk_2Hz = 1'b1; cyc(1); clk_2Hz = 1'b0; cyc(3);
    endtask

    task automatic tick1k();
        clk_1kHz = 1'b1; cyc(1); clk_1kHz = 1'b0; cyc(3);
    endtask

    task automatic press_start();
        start_stop = 1'b1; cyc(1); start_stop = 1'b0; cyc(3);
    endtask

    task automatic press_clear();
        clear = 1'b1; cyc(1); clear = 1'b0; cyc(3);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bcd"}, bcd, 16'h0000);
        chk({tag, "_running"}, {15'd0, running}, 16'd0);
        chk({tag, "_done"}, {15'd0, done}, 16'd0);
        chk({tag, "_seg"}, {9'd0, seg}, 16'h007F);
        chk({tag, "_an"}, {12'd0, an}, 16'h000F);
        chk({tag, "_dp"}, {15'd0, dp}, 16'd1);
    endtask

    initial begin
        int done_cnt;
        cyc(3);
        chk_reset_outputs("reset");
        rst = 1'b1;
        cyc(3);

        // Count up 12 ticks; the last one checked for its two-clock latency
        press_start();
        chk("run_after_start", {15'd0, running}, 16'd1);
        for (int i = 0; i < 11; i++) tick2();
        clk_2Hz = 1'b1; cyc(1); clk_2Hz = 1'b0; cyc(1);
        chk("latency_before", bcd, 16'h0011);
        cyc(1);
        chk("latency_after", bcd, 16'h0012);
        cyc(1);

        // Up to 9999, pause, resume, wrap
        for (int i = 0; i < 9987; i++) tick2();
        chk("reach_9999", bcd, 16'h9999);
        press_start();
        chk("paused", {15'd0, running}, 16'd0);
        press_start();
        tick2();
        chk("wrap_bcd", bcd, 16'h0000);
        chk("wrap_running", {15'd0, running}, 16'd1);
        for (int i = 0; i < 9; i++) tick2();
        chk("nine", bcd, 16'h0009);
        tick2();
        chk("carry_ten", bcd, 16'h0010);

        // Count down to zero
        up_down = 1'b0;
        cyc(3);
        for (int i = 0; i < 7; i++) tick2();
        chk("down_3", bcd, 16'h0003);
        tick2();
        chk("down_2", bcd, 16'h0002);
        tick2();
        chk("down_1", bcd, 16'h0001);
        done_cnt = 0;
        clk_2Hz = 1'b1; cyc(1); clk_2Hz = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            done_cnt += int'(done);
        end
        chk("done_width", 16'(done_cnt), 16'd1);
        chk("down_0", bcd, 16'h0000);
        chk("idle_after_done", {15'd0, running}, 16'd0);
        tick2();
        chk("idle_tick_ignored", bcd, 16'h0000);

        // Clear and start together in RUN
        up_down = 1'b1;
        cyc(3);
        press_start();
        for (int i = 0; i < 456; i++) tick2();
        chk("reach_456", bcd, 16'h0456);
        clear = 1'b1; start_stop = 1'b1; cyc(1);
        clear = 1'b0; start_stop = 1'b0; cyc(3);
        chk("clear_wins_bcd", bcd, 16'h0000);
        chk("clear_wins_idle", {15'd0, running}, 16'd0);

        // Start coincident with a tick
        press_start();
        for (int i = 0; i < 5; i++) tick2();
        start_stop = 1'b1; clk_2Hz = 1'b1; cyc(1);
        start_stop = 1'b0; clk_2Hz = 1'b0; cyc(3);
        chk("coincide_pause", {15'd0, running}, 16'd0);
        chk("coincide_bcd", bcd, 16'h0005);
        for (int i = 0; i < 3; i++) tick2();
        chk("pause_ignores", bcd, 16'h0005);

        // Display scan at 0042 while running
        press_clear();
        press_start();
        for (int i = 0; i < 42; i++) tick2();
        chk("reach_42", bcd, 16'h0042);
        chk("dark_before_scan", {12'd0, an}, 16'h000F);
        tick1k();
        chk("an0", {12'd0, an}, 16'h000E);
        chk("seg0", {9'd0, seg}, 16'h0024);
        chk("dp0", {15'd0, dp}, 16'd0);
        tick1k();
        chk("an1", {12'd0, an}, 16'h000D);
        chk("seg1", {9'd0, seg}, 16'h0019);
        chk("dp1", {15'd0, dp}, 16'd1);
        tick1k();
        chk("an2", {12'd0, an}, 16'h000B);
        chk("seg2", {9'd0, seg}, 16'h007F);
        tick1k();
        chk("an3", {12'd0, an}, 16'h0007);
        chk("seg3", {9'd0, seg}, 16'h007F);

        // Asynchronous reset mid-count
        tick2();
        tick2();
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk_reset_outputs("async_rst");
        cyc(2);
        rst = 1'b1;
        cyc(2);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
